// File: rtl/operand_fetch_if.sv
// Operand-fetch bus: upstream issue, register file read/snoop, downstream entry.
// The slave modport is the operand_fetch side; master is the surrounding pipeline.
interface operand_fetch_if #(
    parameter int n = 32,
    parameter int r = 7
);
    logic         in_valid;
    logic         in_ready;
    logic [r-1:0] in_rs1;
    logic [r-1:0] in_rs2;
    logic [r-1:0] in_rd;
    logic         in_rd_we;
    logic [r-1:0] readReg1;
    logic [r-1:0] readReg2;
    logic [n-1:0] readData1;
    logic [n-1:0] readData2;
    logic         regWrite;
    logic [r-1:0] writeReg;
    logic [n-1:0] writeData;
    logic         flush;
    logic         out_valid;
    logic         out_ready;
    logic [n-1:0] out_rs1_data;
    logic [n-1:0] out_rs2_data;
    logic [r-1:0] out_rd;
    logic         out_rd_we;

    modport slave (
        input  in_valid, in_rs1, in_rs2, in_rd, in_rd_we,
        input  readData1, readData2, regWrite, writeReg, writeData,
        input  flush, out_ready,
        output in_ready, readReg1, readReg2,
        output out_valid, out_rs1_data, out_rs2_data, out_rd, out_rd_we
    );

    modport master (
        output in_valid, in_rs1, in_rs2, in_rd, in_rd_we,
        output readData1, readData2, regWrite, writeReg, writeData,
        output flush, out_ready,
        input  in_ready, readReg1, readReg2,
        input  out_valid, out_rs1_data, out_rs2_data, out_rd, out_rd_we
    );
endinterface

// File: rtl/operand_fetch.sv
// Operand fetch stage: one-entry operand register behind the register file with a
// per-register busy scoreboard. Define OPFETCH_BYPASS_EN to forward same-cycle writebacks.
module operand_fetch #(
    parameter int n = 32,
    parameter int r = 7
) (
    input  logic            clk,
    input  logic            reset,
    operand_fetch_if.slave  bus
);
    localparam int NREG = 2**r;

    typedef struct packed {
        logic [n-1:0] d1;
        logic [n-1:0] d2;
        logic [r-1:0] rd;
        logic         we;
    } entry_t;

    logic [NREG-1:0] busy, busy_nxt;
    entry_t          ent;
    logic            vld;
    logic            wbhit1, wbhit2;
    logic            raw1, raw2, waw, hazard, capture;
    logic [n-1:0]    op1, op2;

    assign bus.readReg1 = bus.in_rs1;
    assign bus.readReg2 = bus.in_rs2;

    assign wbhit1 = bus.regWrite && (bus.writeReg == bus.in_rs1);
    assign wbhit2 = bus.regWrite && (bus.writeReg == bus.in_rs2);

`ifdef OPFETCH_BYPASS_EN
    // A writeback retiring this cycle satisfies the read directly from the snoop port.
    assign raw1 = busy[bus.in_rs1] && !wbhit1;
    assign raw2 = busy[bus.in_rs2] && !wbhit2;
    assign op1  = wbhit1 ? bus.writeData : bus.readData1;
    assign op2  = wbhit2 ? bus.writeData : bus.readData2;
`else
    logic unused_snoop;
    assign unused_snoop = ^{bus.writeData, wbhit1, wbhit2};
    assign raw1 = busy[bus.in_rs1];
    assign raw2 = busy[bus.in_rs2];
    assign op1  = bus.readData1;
    assign op2  = bus.readData2;
`endif

    assign waw          = bus.in_rd_we && busy[bus.in_rd];
    assign hazard       = raw1 || raw2 || waw;
    assign bus.in_ready = !reset && !bus.flush && !hazard && (!vld || bus.out_ready);
    assign capture      = bus.in_valid && bus.in_ready;

    // Clear before set so a same-cycle set on the retiring register wins.
    always_comb begin
        busy_nxt = busy;
        if (bus.regWrite)
            busy_nxt[bus.writeReg] = 1'b0;
        if (capture && bus.in_rd_we)
            busy_nxt[bus.in_rd] = 1'b1;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            vld  <= 1'b0;
            ent  <= '0;
            busy <= '0;
        end else if (bus.flush) begin
            vld  <= 1'b0;
            busy <= '0;
        end else begin
            busy <= busy_nxt;
            if (capture) begin
                vld <= 1'b1;
                ent <= '{d1: op1, d2: op2, rd: bus.in_rd, we: bus.in_rd_we};
            end else if (bus.out_ready) begin
                vld <= 1'b0;
            end
        end
    end

    assign bus.out_valid    = vld;
    assign bus.out_rs1_data = ent.d1;
    assign bus.out_rs2_data = ent.d2;
    assign bus.out_rd       = ent.rd;
    assign bus.out_rd_we    = ent.we;
endmodule

// File: tb/tb_operand_fetch.sv
// Bench for operand_fetch: register file environment, architectural reference model,
// expected-entry queue drained by an independent output monitor.
module tb_operand_fetch;
    localparam int N = 32;
    localparam int R = 7;
`ifdef OPFETCH_BYPASS_EN
    localparam bit BYP = 1'b1;
`else
    localparam bit BYP = 1'b0;
`endif

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    operand_fetch_if #(.n(N), .r(R)) bus();
    operand_fetch #(.n(N), .r(R)) dut (.clk(clk), .reset(reset), .bus(bus));

    // register file environment: write commits at the edge, read is combinational
    logic [N-1:0] regs [0:(1<<R)-1];
    always @(posedge clk) if (bus.regWrite) regs[bus.writeReg] <= bus.writeData;
    assign bus.readData1 = regs[bus.readReg1];
    assign bus.readData2 = regs[bus.readReg2];

    // reference model: architectural register values, outstanding writes, held entries
    typedef struct {
        logic [N-1:0] d1;
        logic [N-1:0] d2;
        logic [R-1:0] rd;
        logic         we;
    } exp_t;
    logic [N-1:0] mrf  [0:(1<<R)-1];
    bit           pend [0:(1<<R)-1];
    exp_t         q[$];
    int checks = 0;
    int errors = 0;
    bit mon_en = 1'b0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
        end
    endtask

    always @(negedge clk) if (mon_en) begin
        chk("out_valid", {63'd0, bus.out_valid}, {63'd0, q.size() != 0});
        if (bus.out_valid && q.size() != 0) begin
            chk("out_rs1_data", {32'd0, bus.out_rs1_data}, {32'd0, q[0].d1});
            chk("out_rs2_data", {32'd0, bus.out_rs2_data}, {32'd0, q[0].d2});
            chk("out_rd",       {57'd0, bus.out_rd},       {57'd0, q[0].rd});
            chk("out_rd_we",    {63'd0, bus.out_rd_we},    {63'd0, q[0].we});
            if (bus.out_ready) void'(q.pop_front());
        end
    end

    // One cycle: entered 1 time unit after a rising edge, returns 1 unit after the next.
    task automatic step(input logic v, input logic [R-1:0] rs1, input logic [R-1:0] rs2,
                        input logic [R-1:0] rd, input logic we, input logic wr,
                        input logic [R-1:0] wreg, input logic [N-1:0] wd,
                        input logic ordy, input logic fl);
        logic haz, erdy, acc, ord;
        exp_t e;
        ord = ordy && !fl;
        bus.in_valid = v;  bus.in_rs1 = rs1; bus.in_rs2 = rs2; bus.in_rd = rd; bus.in_rd_we = we;
        bus.regWrite = wr; bus.writeReg = wreg; bus.writeData = wd;
        bus.out_ready = ord; bus.flush = fl;
        #2;
        haz  = (pend[rs1] && !(BYP && wr && wreg == rs1)) ||
               (pend[rs2] && !(BYP && wr && wreg == rs2)) ||
               (we && pend[rd]);
        erdy = !reset && !fl && !haz && (q.size() == 0 || ord);
        chk("in_ready", {63'd0, bus.in_ready}, {63'd0, erdy});
        chk("readReg1", {57'd0, bus.readReg1}, {57'd0, rs1});
        acc  = v && erdy;
        e.d1 = (BYP && wr && wreg == rs1) ? wd : mrf[rs1];
        e.d2 = (BYP && wr && wreg == rs2) ? wd : mrf[rs2];
        e.rd = rd;
        e.we = we;
        @(posedge clk);
        if (wr) mrf[wreg] = wd;
        if (reset || fl) begin
            q.delete();
            foreach (pend[i]) pend[i] = 1'b0;
        end else begin
            if (wr) pend[wreg] = 1'b0;
            if (acc) begin
                if (we) pend[rd] = 1'b1;
                q.push_back(e);
            end
        end
        #1;
    endtask

    task automatic idle(input logic ordy);
        step(1'b0, '0, '0, '0, 1'b0, 1'b0, '0, '0, ordy, 1'b0);
    endtask

    initial begin
        logic [N-1:0] v;
        for (int i = 0; i < (1<<R); i++) begin
            v = $urandom;
            regs[i] = v; mrf[i] = v; pend[i] = 1'b0;
        end
        regs[3] = 32'h11; mrf[3] = 32'h11;
        regs[4] = 32'h22; mrf[4] = 32'h22;
        reset = 1'b1;
        @(posedge clk); #1;

        // reset held two cycles with an instruction offered
        step(1'b1, 7'd1, 7'd2, 7'd3, 1'b1, 1'b0, '0, '0, 1'b1, 1'b0);
        mon_en = 1'b1;
        step(1'b1, 7'd1, 7'd2, 7'd3, 1'b1, 1'b0, '0, '0, 1'b1, 1'b0);
        reset = 1'b0;
        chk("rst_rs1_data", {32'd0, bus.out_rs1_data}, 64'd0);
        chk("rst_rs2_data", {32'd0, bus.out_rs2_data}, 64'd0);
        chk("rst_rd",       {57'd0, bus.out_rd},       64'd0);
        chk("rst_rd_we",    {63'd0, bus.out_rd_we},    64'd0);

        // back-to-back independent instructions
        step(1'b1, 7'd3, 7'd4, 7'd5, 1'b1, 1'b0, '0, '0, 1'b1, 1'b0);
        step(1'b1, 7'd6, 7'd7, 7'd8, 1'b1, 1'b0, '0, '0, 1'b1, 1'b0);
        idle(1'b1);
        step(1'b0, '0, '0, '0, 1'b0, 1'b1, 7'd5, 32'h55, 1'b1, 1'b0);
        step(1'b0, '0, '0, '0, 1'b0, 1'b1, 7'd8, 32'h88, 1'b1, 1'b0);

        // RAW on r10, writeback three cycles later
        step(1'b1, 7'd1, 7'd2, 7'd10, 1'b1, 1'b0, '0, '0, 1'b1, 1'b0);
        step(1'b1, 7'd10, 7'd2, 7'd11, 1'b0, 1'b0, '0, '0, 1'b1, 1'b0);
        step(1'b1, 7'd10, 7'd2, 7'd11, 1'b0, 1'b0, '0, '0, 1'b1, 1'b0);
        step(1'b1, 7'd10, 7'd2, 7'd11, 1'b0, 1'b1, 7'd10, 32'hABCD, 1'b1, 1'b0);
        step(1'b1, 7'd10, 7'd2, 7'd11, 1'b0, 1'b0, '0, '0, 1'b1, 1'b0);
        idle(1'b1);

        // WAW on r20
        step(1'b1, 7'd1, 7'd2, 7'd20, 1'b1, 1'b0, '0, '0, 1'b1, 1'b0);
        step(1'b1, 7'd3, 7'd4, 7'd20, 1'b1, 1'b0, '0, '0, 1'b1, 1'b0);
        step(1'b1, 7'd3, 7'd4, 7'd20, 1'b1, 1'b1, 7'd20, 32'h2020, 1'b1, 1'b0);
        step(1'b1, 7'd3, 7'd4, 7'd20, 1'b1, 1'b0, '0, '0, 1'b1, 1'b0);
        step(1'b0, '0, '0, '0, 1'b0, 1'b1, 7'd20, 32'h2121, 1'b1, 1'b0);
        idle(1'b1);

        // backpressure for four cycles, then drain and reload in one cycle
        step(1'b1, 7'd5, 7'd6, 7'd30, 1'b0, 1'b0, '0, '0, 1'b0, 1'b0);
        for (int i = 0; i < 4; i++)
            step(1'b1, 7'd7, 7'd8, 7'd31, 1'b0, 1'b0, '0, '0, 1'b0, 1'b0);
        step(1'b1, 7'd7, 7'd8, 7'd31, 1'b0, 1'b0, '0, '0, 1'b1, 1'b0);
        idle(1'b1);

        // flush with an entry held, r10 busy and an instruction offered
        step(1'b1, 7'd1, 7'd2, 7'd10, 1'b1, 1'b0, '0, '0, 1'b0, 1'b0);
        step(1'b1, 7'd3, 7'd4, 7'd12, 1'b1, 1'b0, '0, '0, 1'b1, 1'b1);
        step(1'b1, 7'd10, 7'd10, 7'd13, 1'b0, 1'b0, '0, '0, 1'b1, 1'b0);
        idle(1'b1);

        // randomized traffic over a small register pool to provoke hazards
        for (int c = 0; c < 4000; c++) begin
            logic [R-1:0] a1, a2, ad, wreg;
            logic wr;
            int cand[$];
            a1 = ($urandom_range(15) == 0) ? R'($urandom_range(127)) : R'($urandom_range(7));
            a2 = ($urandom_range(15) == 0) ? R'($urandom_range(127)) : R'($urandom_range(7));
            ad = ($urandom_range(15) == 0) ? R'($urandom_range(127)) : R'($urandom_range(7));
            cand.delete();
            foreach (pend[i]) if (pend[i]) cand.push_back(i);
            wr = 1'b0; wreg = '0;
            if (cand.size() != 0 && $urandom_range(99) < 40) begin
                wr = 1'b1; wreg = R'(cand[$urandom_range(cand.size() - 1)]);
            end else if ($urandom_range(99) < 5) begin
                wr = 1'b1; wreg = R'($urandom_range(7));
            end
            step($urandom_range(99) < 70, a1, a2, ad, $urandom_range(99) < 60,
                 wr, wreg, $urandom, $urandom_range(99) < 75, $urandom_range(99) < 2);
        end

        for (int i = 0; i < 3; i++) idle(1'b1);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
